// File: rtl/mac_mdc_package.sv
// Shared types and constants for the mac_mdc engine: kernel adapter handshake
// structs, engine sequencer state encoding and default counter widths.
package mac_mdc_package;

    localparam int unsigned MAC_MDC_CNT_W  = 16;
    localparam int unsigned MAC_MDC_WDOG_W = 12;

    typedef struct packed {
        logic start;
    } ctrl_kernel_adapter_t;

    typedef struct packed {
        logic done;
        logic ready;
        logic idle;
    } flags_kernel_adapter_t;

    typedef enum logic [2:0] {
        ENG_IDLE,
        ENG_START,
        ENG_WAIT_RDY,
        ENG_WAIT_DONE,
        ENG_DRAIN,
        ENG_ERROR
    } mac_mdc_engine_state_t;

endpackage

// File: rtl/mac_mdc_watchdog.sv
// Cycle watchdog: counts while enabled, restarts on clear, and flags the cycle
// that completes 2^WDOG_W-1 consecutive enabled cycles.
module mac_mdc_watchdog
    import mac_mdc_package::*;
#(
    parameter int unsigned WDOG_W = MAC_MDC_WDOG_W
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_c
);

    // The count holds 0..TERM, so the cycle seeing TERM is the last tolerated one.
    localparam logic [WDOG_W-1:0] TERM = ~WDOG_W'(1);

    logic [WDOG_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_c = enable_i && (cnt_q == TERM);

endmodule

// File: rtl/mac_mdc_engine_fsm.sv
// Control-side sequencer of the mac_mdc kernel adapter: issues one kernel start
// per output element, counts completions against the job length, guards with a watchdog.
module mac_mdc_engine_fsm
    import mac_mdc_package::*;
#(
    parameter int unsigned CNT_W  = MAC_MDC_CNT_W,
    parameter int unsigned WDOG_W = MAC_MDC_WDOG_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  trigger_i,
    input  logic [CNT_W-1:0]      len_i,
    input  flags_kernel_adapter_t flags_i,
    output ctrl_kernel_adapter_t  ctrl_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [CNT_W-1:0]      cnt_o
);

    mac_mdc_engine_state_t state_d, state_q;
    logic [CNT_W-1:0]      len_d, len_q;
    logic [CNT_W-1:0]      cnt_d, cnt_q;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  start_d, start_q;
    logic                  busy_d, busy_q;
    logic                  done_d, done_q;
    logic                  err_d, err_q;
    logic                  wd_en, wd_clr, wd_expire_c;

    // Watchdog enable comes from the current state only, keeping the expire path acyclic.
    assign wd_en  = (state_q == ENG_WAIT_RDY) || (state_q == ENG_WAIT_DONE) ||
                    (state_q == ENG_DRAIN);
    assign wd_clr = clear_i || (state_d != state_q) || flags_i.done;

    mac_mdc_watchdog #(
        .WDOG_W (WDOG_W)
    ) i_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (wd_clr),
        .enable_i (wd_en),
        .expire_c (wd_expire_c)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_inc = cnt_q + CNT_W'(1);

        if (clear_i) begin
            state_d = ENG_IDLE;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ENG_IDLE: begin
                    if (trigger_i) begin
                        if (len_i != '0) begin
                            len_d   = len_i;
                            cnt_d   = '0;
                            state_d = ENG_START;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ENG_START: begin
                    state_d = ENG_WAIT_RDY;
                end
                ENG_WAIT_RDY: begin
                    // A done arriving together with ready completes the element directly.
                    if (flags_i.ready && flags_i.done) begin
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == len_q) ? ENG_DRAIN : ENG_START;
                    end else if (flags_i.ready) begin
                        state_d = ENG_WAIT_DONE;
                    end else if (wd_expire_c && !flags_i.done) begin
                        state_d = ENG_ERROR;
                        err_d   = 1'b1;
                    end
                end
                ENG_WAIT_DONE: begin
                    if (flags_i.done) begin
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == len_q) ? ENG_DRAIN : ENG_START;
                    end else if (wd_expire_c) begin
                        state_d = ENG_ERROR;
                        err_d   = 1'b1;
                    end
                end
                ENG_DRAIN: begin
                    if (flags_i.idle) begin
                        done_d  = 1'b1;
                        state_d = ENG_IDLE;
                    end else if (wd_expire_c && !flags_i.done) begin
                        state_d = ENG_ERROR;
                        err_d   = 1'b1;
                    end
                end
                ENG_ERROR: begin
                    state_d = ENG_ERROR;
                end
                default: begin
                    state_d = ENG_IDLE;
                end
            endcase
        end

        start_d = (state_d == ENG_START);
        busy_d  = (state_d == ENG_START) || (state_d == ENG_WAIT_RDY) ||
                  (state_d == ENG_WAIT_DONE) || (state_d == ENG_DRAIN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ENG_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ctrl_o.start = start_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_mac_mdc_engine_fsm.sv
// Self-checking bench for mac_mdc_engine_fsm: a reactive kernel model drives
// ready/done/idle and expected timing is derived from per-element latencies.
module tb_mac_mdc_engine_fsm;
    import mac_mdc_package::*;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WDOG_W = 4;
    localparam int unsigned WDOG_TIMEOUT = (1 << WDOG_W) - 1;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  clear_i;
    logic                  trigger_i;
    logic [CNT_W-1:0]      len_i;
    flags_kernel_adapter_t flags_i;
    ctrl_kernel_adapter_t  ctrl_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;
    logic [CNT_W-1:0]      cnt_o;

    int n_checks   = 0;
    int n_errors   = 0;
    int start_seen = 0;
    int done_seen  = 0;

    mac_mdc_engine_fsm #(
        .CNT_W  (CNT_W),
        .WDOG_W (WDOG_W)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .trigger_i (trigger_i),
        .len_i     (len_i),
        .flags_i   (flags_i),
        .ctrl_o    (ctrl_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .cnt_o     (cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Independent pulse counters for start and job-complete.
    always @(posedge clk_i) begin
        if (ctrl_o.start) start_seen++;
        if (done_o) done_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic noise_trig(input bit noisy);
        trigger_i = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    // Entered in a cycle where ctrl_o.start is high; returns in the cycle after done.
    task automatic elem(input int rd, input int dn, input int exp_cnt, input bit last,
                        input bit noisy);
        flags_i.ready = 1'b0;
        flags_i.done  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        flags_i.idle  = 1'b0;
        noise_trig(noisy);
        for (int k = 1; k <= dn; k++) begin
            step();
            check_eq("start_single", 32'(ctrl_o.start), 0);
            flags_i.ready = (k == rd);
            flags_i.done  = (k == dn);
            noise_trig(noisy);
        end
        step();
        flags_i.ready = 1'b0;
        flags_i.done  = 1'b0;
        trigger_i     = 1'b0;
        check_eq("cnt_step", 32'(cnt_o), 32'(exp_cnt));
        check_eq("start_next", 32'(ctrl_o.start), last ? 0 : 1);
        check_eq("busy_in_job", 32'(busy_o), 1);
    endtask

    // Entered with trigger_i/len_i set in an IDLE cycle; returns in the done_o cycle.
    task automatic job_body(input int len, input int idle_lat, input int next_len,
                            input bit noisy, input int rd_fix, input int dn_fix);
        int s0;
        int rd;
        int dn;
        step();
        trigger_i = 1'b0;
        check_eq("trig_to_start", 32'(ctrl_o.start), 1);
        check_eq("start_busy", 32'(busy_o), 1);
        check_eq("start_cnt0", 32'(cnt_o), 0);
        check_eq("start_no_done", 32'(done_o), 0);
        s0 = start_seen;
        for (int e = 0; e < len; e++) begin
            rd = (rd_fix != 0) ? rd_fix : int'($urandom_range(1, 4));
            dn = (dn_fix != 0) ? dn_fix : rd + int'($urandom_range(0, 4));
            elem(rd, dn, e + 1, e == len - 1, noisy);
        end
        for (int j = 0; j < idle_lat; j++) begin
            flags_i.idle = 1'b0;
            flags_i.done = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            noise_trig(noisy);
            step();
            check_eq("drain_no_done", 32'(done_o), 0);
            check_eq("drain_cnt", 32'(cnt_o), 32'(len));
        end
        flags_i.idle = 1'b1;
        flags_i.done = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        noise_trig(noisy);
        step();
        flags_i.done = 1'b0;
        check_eq("job_done", 32'(done_o), 1);
        check_eq("job_busy_fall", 32'(busy_o), 0);
        check_eq("job_cnt_final", 32'(cnt_o), 32'(len));
        check_eq("job_starts", 32'(start_seen - s0), 32'(len));
        if (next_len > 0) begin
            trigger_i = 1'b1;
            len_i     = CNT_W'(next_len);
        end else begin
            trigger_i = 1'b0;
        end
    endtask

    task automatic after_job();
        step();
        check_eq("post_done_low", 32'(done_o), 0);
        check_eq("post_busy_low", 32'(busy_o), 0);
        check_eq("post_start_low", 32'(ctrl_o.start), 0);
    endtask

    initial begin
        int cur;
        int nxt;
        int d0;

        rst_ni    = 1'b0;
        clear_i   = 1'b0;
        trigger_i = 1'b0;
        len_i     = '0;
        flags_i   = '{done: 1'b0, ready: 1'b0, idle: 1'b1};
        #12;
        check_eq("rst_start", 32'(ctrl_o.start), 0);
        check_eq("rst_busy", 32'(busy_o), 0);
        check_eq("rst_done", 32'(done_o), 0);
        check_eq("rst_err", 32'(err_o), 0);
        check_eq("rst_cnt", 32'(cnt_o), 0);
        step();
        rst_ni = 1'b1;
        step();

        // Zero-length job
        trigger_i = 1'b1;
        len_i     = '0;
        step();
        trigger_i = 1'b0;
        check_eq("zero_done", 32'(done_o), 1);
        check_eq("zero_start", 32'(ctrl_o.start), 0);
        check_eq("zero_busy", 32'(busy_o), 0);
        check_eq("zero_cnt", 32'(cnt_o), 0);
        after_job();
        check_eq("zero_cnt_after", 32'(cnt_o), 0);

        // Basic job, fixed kernel latencies
        trigger_i = 1'b1;
        len_i     = CNT_W'(4);
        job_body(4, 2, 0, 1'b0, 2, 5);
        after_job();

        // Ready and done in the same cycle
        trigger_i = 1'b1;
        len_i     = CNT_W'(2);
        job_body(2, 1, 0, 1'b0, 3, 3);
        after_job();

        // Directed back-to-back: trigger held through done_o
        trigger_i = 1'b1;
        len_i     = CNT_W'(3);
        job_body(3, 1, 2, 1'b1, 0, 0);
        job_body(2, 0, 0, 1'b0, 0, 0);
        after_job();

        // Randomized jobs with mid-job trigger noise and spurious done pulses
        cur       = int'($urandom_range(1, 6));
        trigger_i = 1'b1;
        len_i     = CNT_W'(cur);
        for (int it = 0; it < 8; it++) begin
            nxt = (it < 7 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
            job_body(cur, int'($urandom_range(0, 5)), nxt, 1'b1, 0, 0);
            if (nxt > 0) begin
                cur = nxt;
            end else begin
                after_job();
                if (it < 7) begin
                    cur       = int'($urandom_range(1, 6));
                    trigger_i = 1'b1;
                    len_i     = CNT_W'(cur);
                end
            end
        end

        // Watchdog: kernel never answers
        trigger_i = 1'b1;
        len_i     = CNT_W'(3);
        step();
        trigger_i = 1'b0;
        flags_i   = '{done: 1'b0, ready: 1'b0, idle: 1'b0};
        check_eq("wd_start", 32'(ctrl_o.start), 1);
        for (int k = 1; k <= int'(WDOG_TIMEOUT); k++) begin
            step();
            check_eq("wd_early", 32'(err_o), 0);
        end
        step();
        check_eq("wd_err", 32'(err_o), 1);
        check_eq("wd_busy", 32'(busy_o), 0);
        trigger_i = 1'b1;
        len_i     = CNT_W'(2);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("err_trig_ignored", 32'(ctrl_o.start), 0);
            check_eq("err_sticky", 32'(err_o), 1);
            check_eq("err_not_busy", 32'(busy_o), 0);
        end
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check_eq("clr_err", 32'(err_o), 0);
        check_eq("clr_no_start", 32'(ctrl_o.start), 0);
        check_eq("clr_busy", 32'(busy_o), 0);
        check_eq("clr_cnt", 32'(cnt_o), 0);
        job_body(2, 0, 0, 1'b0, 1, 2);
        after_job();

        // Clear mid-job at cnt 2 of 5
        trigger_i = 1'b1;
        len_i     = CNT_W'(5);
        step();
        trigger_i = 1'b0;
        check_eq("abort_start", 32'(ctrl_o.start), 1);
        elem(2, 3, 1, 1'b0, 1'b0);
        elem(1, 2, 2, 1'b0, 1'b0);
        d0      = done_seen;
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        flags_i.idle = 1'b1;
        check_eq("abort_busy", 32'(busy_o), 0);
        check_eq("abort_cnt", 32'(cnt_o), 0);
        check_eq("abort_start_low", 32'(ctrl_o.start), 0);
        for (int k = 0; k < 5; k++) step();
        check_eq("abort_no_done", 32'(done_seen - d0), 0);
        trigger_i = 1'b1;
        len_i     = CNT_W'(1);
        job_body(1, 1, 0, 1'b0, 2, 3);
        after_job();

        // Asynchronous reset mid-job
        trigger_i = 1'b1;
        len_i     = CNT_W'(3);
        step();
        trigger_i = 1'b0;
        elem(1, 2, 1, 1'b0, 1'b0);
        d0     = done_seen;
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("arst_cnt", 32'(cnt_o), 0);
        check_eq("arst_busy", 32'(busy_o), 0);
        check_eq("arst_start", 32'(ctrl_o.start), 0);
        step();
        rst_ni = 1'b1;
        step();
        step();
        check_eq("arst_no_done", 32'(done_seen - d0), 0);
        check_eq("arst_idle", 32'(busy_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
